sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 4, maximum in-flight accepted requests; power of two, >=2.
REQ-002 Parameter STARVE_LIM, default 8, consecutive lost cycles before the inst port is forced to win.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 {inst,data}_req  input  1  master request, held until the matching addr_ok.
REQ-006 {inst,data}_wr  input  1  1=write, 0=read.
REQ-007 {inst,data}_size  input  2  0=byte, 1=half, 2=word.
REQ-008 {inst,data}_wstrb  input  4  byte strobes.
REQ-009 {inst,data}_addr  input  32  physical address.
REQ-010 {inst,data}_wdata  input  32  write data.
REQ-011 {inst,data}_addr_ok  output  1  request accepted this cycle.
REQ-012 {inst,data}_data_ok  output  1  response for this master this cycle.
REQ-013 {inst,data}_rdata  output  32  read data; valid with data_ok.
REQ-014 mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  output  1/1/2/4/32/32  shared slave request.
REQ-015 mem_addr_ok  input  1  slave accepted mem_req.
REQ-016 mem_data_ok  input  1  slave response; in request order.
REQ-017 mem_rdata  input  32  slave read data.
REQ-018 err_unexp  output  1  sticky: mem_data_ok with nothing in flight.

Function
REQ-019 Accept = mem_req & mem_addr_ok; exactly one master's addr_ok is high on accept, the granted one; none otherwise.
REQ-020 mem_req = granted master's req & ~full; all other mem_* outputs mux from the granted master, combinationally, zero latency.
REQ-021 Grant selection when unlocked: data wins if data_req; else inst if inst_req; exception: when starve_cnt == STARVE_LIM and inst_req, inst wins.
REQ-022 Lock: if mem_req is high and not accepted, the grant is registered and held until accept; no switching mid-request.
REQ-023 starve_cnt: +1 each cycle inst_req is high and inst is not accepted; cleared on inst accept or inst_req low; saturates at STARVE_LIM.
REQ-024 Order FIFO, OUTSTANDING entries x 1 bit (0=inst, 1=data): push grant id on accept; pop on mem_data_ok with count>0.
REQ-025 Routing: on mem_data_ok, head id selects which data_ok pulses; both rdata outputs equal mem_rdata.
REQ-026 full = (count == OUTSTANDING); while full, mem_req=0 and no addr_ok, even with mem_addr_ok high.
REQ-027 Push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo OUTSTANDING.
REQ-028 Pop at full and push in the same cycle is impossible (REQ-026); accept in the cycle full deasserts is allowed next cycle only.
REQ-029 mem_data_ok with count==0: no data_ok pulses, FIFO unchanged, err_unexp set and held until reset.
REQ-030 Response latency: data_ok is the same cycle as mem_data_ok; a response may share a cycle with an accept for either master.

Reset
REQ-031 On resetn=0 at a clock edge: count, pointers, lock, starve_cnt, err_unexp = 0; outputs addr_ok/data_ok = 0 next cycle.
REQ-032 Reset mid-operation discards all in-flight entries; the slave shares resetn and issues no later responses for them.

Verification
REQ-033 Both req high from reset, mem_addr_ok=1 always -> data accepted every cycle, inst_addr_ok first at cycle 9 (STARVE_LIM=8), then data resumes.
REQ-034 data_req then inst_req, mem_addr_ok low 3 cycles -> mem_addr stays data_addr all 3 cycles; data_addr_ok on 4th cycle.
REQ-035 4 accepts (inst,data,data,inst), no response -> 5th request blocked, mem_req=0; one mem_data_ok -> inst_data_ok, next accept proceeds.
REQ-036 Responses with rdata 0x11,0x22,0x33 after accepts inst,data,inst -> inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
REQ-037 count=4, pointers wrapped, simultaneous accept and response at count=3 -> count stays 3, order preserved across wrap.
REQ-038 mem_data_ok with count=0 -> no data_ok, err_unexp=1 held; resetn=0 one cycle -> err_unexp=0, count=0.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-master (instruction/data) arbiter onto a single pipelined SRAM-style slave.
// The data port has priority, an anti-starvation counter eventually forces the
// instruction port through, a stalled grant stays locked until the slave
// accepts it, and a small ID FIFO routes in-order responses back to their master.
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_LIM  = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_unexp
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    // Order FIFO: one bit per in-flight request, 0 = inst, 1 = data
    logic [OUTSTANDING-1:0] fifo_id;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic                   locked;
    logic                   locked_id;
    logic [SW-1:0]          starve_cnt;
    logic                   err_q;

    logic                   grant_data;
    logic                   full;
    logic                   accept;
    logic                   pop;
    logic                   head_id;

    // Grant selection: a locked grant wins; otherwise data first unless inst has starved
    always_comb begin
        grant_data = 1'b0;
        if (locked) begin
            grant_data = locked_id;
        end else if (inst_req && (starve_cnt == SW'(STARVE_LIM))) begin
            grant_data = 1'b0;
        end else if (data_req) begin
            grant_data = 1'b1;
        end
    end

    // Slave request mux, handshake qualification and response routing (zero latency)
    always_comb begin
        full      = (count == CW'(OUTSTANDING));
        mem_req   = resetn & ~full & (grant_data ? data_req : inst_req);
        mem_wr    = grant_data ? data_wr    : inst_wr;
        mem_size  = grant_data ? data_size  : inst_size;
        mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
        mem_addr  = grant_data ? data_addr  : inst_addr;
        mem_wdata = grant_data ? data_wdata : inst_wdata;

        accept       = mem_req & mem_addr_ok;
        inst_addr_ok = accept & ~grant_data;
        data_addr_ok = accept &  grant_data;

        // A response with nothing in flight is dropped (and flagged below)
        pop          = resetn & mem_data_ok & (count != '0);
        head_id      = fifo_id[rd_ptr];
        inst_data_ok = pop & ~head_id;
        data_data_ok = pop &  head_id;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;

        err_unexp    = err_q;
    end

    // Control state: FIFO pointers/occupancy, grant lock, starvation counter, error flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            locked     <= 1'b0;
            locked_id  <= 1'b0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            // Pointers wrap naturally because OUTSTANDING is a power of two
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);

            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Hold the grant while the slave stalls an offered request
            locked    <= mem_req & ~mem_addr_ok;
            locked_id <= grant_data;

            if (!inst_req || (accept && !grant_data)) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (mem_data_ok && (count == '0)) err_q <= 1'b1;
        end
    end

    // FIFO storage holds payload only, so it is not reset
    always_ff @(posedge clk) begin
        if (accept) fifo_id[wr_ptr] <= grant_data;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model of the arbiter rules.
module tb_sram_req_arbiter;

    localparam int OUTSTANDING = 4;
    localparam int STARVE_LIM  = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [3:0]  inst_wstrb = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_unexp;

    sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: in-flight master ids in issue order, pending (stalled) grant,
    // consecutive-loss counter for the inst port, sticky error.
    bit m_q[$];
    bit m_held;
    bit m_held_id;
    int m_starve;
    bit m_err;

    bit last_iacc, last_dacc;
    bit obs_mreq, obs_iaok, obs_daok, obs_idok, obs_ddok, obs_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check mid-cycle, advance the model, cross the edge
    task automatic step();
        bit full, g, greq, mreq, acc, pop, hid;
        #3;
        full = (m_q.size() == OUTSTANDING);
        if (m_held)                                 g = m_held_id;
        else if (inst_req && m_starve == STARVE_LIM) g = 1'b0;
        else                                        g = data_req;
        greq = g ? data_req : inst_req;
        mreq = resetn && greq && !full;
        acc  = mreq && mem_addr_ok;
        pop  = resetn && mem_data_ok && (m_q.size() > 0);
        hid  = pop ? m_q[0] : 1'b0;

        obs_mreq = mem_req;      obs_iaok = inst_addr_ok; obs_daok = data_addr_ok;
        obs_idok = inst_data_ok; obs_ddok = data_data_ok; obs_err  = err_unexp;

        chk("mem_req", mem_req, mreq);
        if (mreq) begin
            chk("mem_addr", mem_addr, g ? data_addr : inst_addr);
            chk("mem_ctl", {mem_wr, mem_size, mem_wstrb},
                g ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
            chk("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
        end
        chk("inst_addr_ok", inst_addr_ok, acc && !g);
        chk("data_addr_ok", data_addr_ok, acc && g);
        chk("inst_data_ok", inst_data_ok, pop && !hid);
        chk("data_data_ok", data_data_ok, pop && hid);
        if (pop) begin
            chk("inst_rdata", inst_rdata, mem_rdata);
            chk("data_rdata", data_rdata, mem_rdata);
        end
        chk("err_unexp", err_unexp, m_err);

        last_iacc = acc && !g;
        last_dacc = acc && g;

        if (!resetn) begin
            m_q.delete();
            m_held = 0; m_held_id = 0; m_starve = 0; m_err = 0;
        end else begin
            if (mem_data_ok && m_q.size() == 0) m_err = 1;
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(g);
            m_held    = mreq && !mem_addr_ok;
            m_held_id = g;
            if (inst_req && !(acc && !g))
                m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
            else
                m_starve = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 0; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        step();
        step();
        resetn = 1;
    endtask

    task automatic roll_inst();
        inst_req   = ($urandom_range(0, 3) != 0);
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
    endtask

    task automatic roll_data();
        data_req   = ($urandom_range(0, 3) != 0);
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    initial begin
        int first_inst;
        m_held = 0; m_held_id = 0; m_starve = 0; m_err = 0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        chk("reset_mem_req", obs_mreq, 0);
        chk("reset_err", obs_err, 0);

        // Both masters request continuously: data wins until inst has lost STARVE_LIM cycles
        roll_inst(); roll_data();
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        first_inst = -1;
        for (int c = 1; c <= 14; c++) begin
            mem_data_ok = (m_q.size() > 0);
            mem_rdata   = $urandom;
            step();
            if (obs_iaok && first_inst < 0) first_inst = c;
            if (last_iacc) inst_addr = $urandom;
            if (last_dacc) data_addr = $urandom;
        end
        chk("starve_first_inst_cycle", first_inst, 9);

        // Stalled data request stays granted while inst also asks
        do_reset();
        roll_inst(); roll_data();
        inst_req = 0; data_req = 1; mem_addr_ok = 0;
        step();
        inst_req = 1;
        step();
        step();
        mem_addr_ok = 1;
        step();
        chk("lock_data_accept", obs_daok, 1);
        data_req = 0;
        step();
        chk("lock_then_inst_accept", obs_iaok, 1);

        // Fill the FIFO with inst,data,data,inst and no responses, then release one
        do_reset();
        mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            inst_req = (k == 0 || k == 3);
            data_req = (k == 1 || k == 2);
            inst_addr = $urandom; data_addr = $urandom;
            step();
        end
        inst_req = 1; data_req = 1;
        step();
        chk("full_blocks_mem_req", obs_mreq, 0);
        chk("full_blocks_addr_ok", obs_iaok | obs_daok, 0);
        mem_data_ok = 1; mem_rdata = 32'h11;
        step();
        chk("full_pop_inst_data_ok", obs_idok, 1);
        chk("full_pop_no_accept", obs_mreq, 0);
        mem_data_ok = 0;
        step();
        chk("after_full_accept", obs_daok, 1);

        // Randomized traffic, slow then fast responses so the FIFO fills and wraps
        for (int i = 0; i < 1500; i++) begin
            if (!inst_req || last_iacc) roll_inst();
            if (!data_req || last_dacc) roll_data();
            mem_addr_ok = ($urandom_range(0, 9) < 6);
            mem_data_ok = (m_q.size() > 0) && ($urandom_range(0, 9) < ((i < 750) ? 2 : 6));
            mem_rdata   = $urandom;
            step();
        end

        // Drain everything still in flight
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        for (int k = 0; k < 2 * OUTSTANDING && m_q.size() > 0; k++) begin
            mem_data_ok = 1; mem_rdata = $urandom;
            step();
        end
        chk("drained", m_q.size(), 0);

        // Unexpected response: no routing, sticky error until reset
        mem_data_ok = 1;
        step();
        chk("unexp_no_inst_data_ok", obs_idok, 0);
        chk("unexp_no_data_data_ok", obs_ddok, 0);
        mem_data_ok = 0;
        step();
        chk("unexp_err_set", obs_err, 1);
        step();
        chk("unexp_err_held", obs_err, 1);
        do_reset();
        chk("unexp_err_cleared", obs_err, 0);
        inst_req = 1; mem_addr_ok = 1;
        step();
        chk("post_reset_accept", obs_iaok, 1);
        inst_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
